// File: rtl/shift_seq_ctrl_if.sv
// Bundle between the ALU issue logic, the shift controller and the two external shift stages.
// The master side issues requests and returns stage results; the slave side is the controller.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
);
    // Handshake: START is a one-cycle request that is honoured only when BUSY=0.
    // DIR/AMT/DIN are sampled on that same edge. DONE pulses for exactly one cycle
    // when DOUT holds the result.
    logic             START;
    logic             DIR;
    logic [AMT_W-1:0] AMT;
    logic [WIDTH-1:0] DIN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] DOUT;
    logic [WIDTH-1:0] STG_IN;
    logic             C_L_SHIFT, C_NO_SHIFT, C_R_SHIFT;
    logic             C_LEFT_NOT, C_OLD_NOT, C_RIGHT_NOT;
    logic             F_L_SHIFT, F_NO_SHIFT, F_R_SHIFT;
    logic             F_LEFT_NOT, F_OLD_NOT, F_RIGHT_NOT;
    logic [WIDTH-1:0] C_OUT;
    logic [WIDTH-1:0] F_OUT;
    logic [1:0]       state_dbg;

    modport master (
        output START, DIR, AMT, DIN, C_OUT, F_OUT,
        input  BUSY, DONE, DOUT, STG_IN,
        input  C_L_SHIFT, C_NO_SHIFT, C_R_SHIFT, C_LEFT_NOT, C_OLD_NOT, C_RIGHT_NOT,
        input  F_L_SHIFT, F_NO_SHIFT, F_R_SHIFT, F_LEFT_NOT, F_OLD_NOT, F_RIGHT_NOT,
        input  state_dbg
    );

    modport slave (
        input  START, DIR, AMT, DIN, C_OUT, F_OUT,
        output BUSY, DONE, DOUT, STG_IN,
        output C_L_SHIFT, C_NO_SHIFT, C_R_SHIFT, C_LEFT_NOT, C_OLD_NOT, C_RIGHT_NOT,
        output F_L_SHIFT, F_NO_SHIFT, F_R_SHIFT, F_LEFT_NOT, F_OLD_NOT, F_RIGHT_NOT,
        output state_dbg
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle logical shifter controller: walks a 32-bit word through an external
// shift-by-4 stage and shift-by-1 stage until the requested amount is consumed.
module shift_seq_ctrl #(
    parameter int WIDTH  = 32,
    parameter int AMT_W  = 5,
    parameter int COARSE = 4
) (
    input logic             CLK,
    input logic             RST_N,
    shift_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [AMT_W-1:0] COARSE_AMT = AMT_W'(COARSE);
    localparam logic [AMT_W-1:0] FINE_AMT   = AMT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] wreg_q, wreg_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             dirr_q, dirr_d;
    logic             coarse_act, fine_act;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            wreg_q  <= '0;
            cnt_q   <= '0;
            dirr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wreg_q  <= wreg_d;
            cnt_q   <= cnt_d;
            dirr_q  <= dirr_d;
        end
    end

    // Stage activity depends only on registered state so the selects are glitch-free
    // with respect to the request inputs.
    always_comb begin
        coarse_act = (state_q == S_RUN) && (cnt_q >= COARSE_AMT);
        fine_act   = (state_q == S_RUN) && (cnt_q <  COARSE_AMT);
    end

    always_comb begin
        state_d = state_q;
        wreg_d  = wreg_q;
        cnt_d   = cnt_q;
        dirr_d  = dirr_q;
        case (state_q)
            S_RUN: begin
                if (coarse_act) begin
                    wreg_d = bus.C_OUT;
                    cnt_d  = cnt_q - COARSE_AMT;
                end else begin
                    wreg_d = bus.F_OUT;
                    cnt_d  = cnt_q - FINE_AMT;
                end
                state_d = (cnt_d == '0) ? S_DONE : S_RUN;
            end
            default: begin
                // IDLE and DONE both accept; DONE otherwise falls back to IDLE.
                if (state_q == S_DONE) state_d = S_IDLE;
                if (bus.START) begin
                    wreg_d  = bus.DIN;
                    cnt_d   = bus.AMT;
                    dirr_d  = bus.DIR;
                    state_d = (bus.AMT != '0) ? S_RUN : S_DONE;
                end
            end
        endcase
    end

    assign bus.BUSY      = (state_q == S_RUN);
    assign bus.DONE      = (state_q == S_DONE);
    assign bus.DOUT      = wreg_q;
    assign bus.STG_IN    = wreg_q;
    assign bus.state_dbg = state_q;

    assign bus.C_L_SHIFT   = coarse_act & dirr_q;
    assign bus.C_R_SHIFT   = coarse_act & ~dirr_q;
    assign bus.C_NO_SHIFT  = ~coarse_act;
    assign bus.C_LEFT_NOT  = ~bus.C_L_SHIFT;
    assign bus.C_RIGHT_NOT = ~bus.C_R_SHIFT;
    assign bus.C_OLD_NOT   = ~bus.C_NO_SHIFT;

    assign bus.F_L_SHIFT   = fine_act & dirr_q;
    assign bus.F_R_SHIFT   = fine_act & ~dirr_q;
    assign bus.F_NO_SHIFT  = ~fine_act;
    assign bus.F_LEFT_NOT  = ~bus.F_L_SHIFT;
    assign bus.F_RIGHT_NOT = ~bus.F_R_SHIFT;
    assign bus.F_OLD_NOT   = ~bus.F_NO_SHIFT;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: models the two external shift stages, drives directed and
// random requests, and scores each DONE against a plain-arithmetic reference.
module tb_shift_seq_ctrl;
    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    shift_seq_ctrl_if #(.WIDTH(32), .AMT_W(5)) bus ();

    shift_seq_ctrl #(.WIDTH(32), .AMT_W(5), .COARSE(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    // External stages: logical shifts with zero fill, pass-through when NO_SHIFT.
    assign bus.C_OUT = bus.C_L_SHIFT ? (bus.STG_IN << 4) :
                       bus.C_R_SHIFT ? (bus.STG_IN >> 4) : bus.STG_IN;
    assign bus.F_OUT = bus.F_L_SHIFT ? (bus.STG_IN << 1) :
                       bus.F_R_SHIFT ? (bus.STG_IN >> 1) : bus.STG_IN;

    logic [31:0] exp_q[$];
    int          exp_steps_q[$];
    int          checks = 0;
    int          errors = 0;
    int          run_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the result is just the shift itself; the step count is coarse then fine.
    task automatic push_expected(input logic dir, input logic [4:0] amt, input logic [31:0] din);
        logic [31:0] r;
        r = dir ? (din << amt) : (din >> amt);
        exp_q.push_back(r);
        exp_steps_q.push_back(int'(amt) / 4 + int'(amt) % 4);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.BUSY === 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (bus.BUSY !== 1'b0) check("busy_timeout", {31'd0, bus.BUSY}, 32'd0);
    endtask

    task automatic issue(input logic dir, input logic [4:0] amt, input logic [31:0] din);
        wait_idle();
        bus.START = 1'b1;
        bus.DIR   = dir;
        bus.AMT   = amt;
        bus.DIN   = din;
        push_expected(dir, amt, din);
        @(negedge CLK);
        bus.START = 1'b0;
        bus.DIN   = $urandom;
    endtask

    task automatic issue_after_done(input logic dir, input logic [4:0] amt, input logic [31:0] din);
        int n;
        n = 0;
        while (bus.DONE !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("done_wait", {31'd0, bus.DONE}, 32'd1);
        issue(dir, amt, din);
    endtask

    task automatic pulse_ignored();
        check("busy_before_ignored_start", {31'd0, bus.BUSY}, 32'd1);
        bus.START = 1'b1;
        bus.DIR   = 1'($urandom);
        bus.AMT   = 5'($urandom);
        bus.DIN   = 32'hFFFF_FFFF;
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    task automatic check_quiet_selects(input string tag);
        check({tag, "_dout"},  bus.DOUT, 32'd0);
        check({tag, "_busy"},  {31'd0, bus.BUSY}, 32'd0);
        check({tag, "_done"},  {31'd0, bus.DONE}, 32'd0);
        check({tag, "_csel"},  {29'd0, bus.C_L_SHIFT, bus.C_NO_SHIFT, bus.C_R_SHIFT}, 32'b010);
        check({tag, "_cnot"},  {29'd0, bus.C_LEFT_NOT, bus.C_OLD_NOT, bus.C_RIGHT_NOT}, 32'b101);
        check({tag, "_fsel"},  {29'd0, bus.F_L_SHIFT, bus.F_NO_SHIFT, bus.F_R_SHIFT}, 32'b010);
        check({tag, "_fnot"},  {29'd0, bus.F_LEFT_NOT, bus.F_OLD_NOT, bus.F_RIGHT_NOT}, 32'b101);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every DONE.
    always @(negedge CLK) begin
        logic ok;
        logic c_act, f_act;
        c_act = ~bus.C_NO_SHIFT;
        f_act = ~bus.F_NO_SHIFT;
        ok = $onehot({bus.C_L_SHIFT, bus.C_NO_SHIFT, bus.C_R_SHIFT}) &&
             $onehot({bus.F_L_SHIFT, bus.F_NO_SHIFT, bus.F_R_SHIFT}) &&
             (bus.C_LEFT_NOT == ~bus.C_L_SHIFT) && (bus.C_OLD_NOT == ~bus.C_NO_SHIFT) &&
             (bus.C_RIGHT_NOT == ~bus.C_R_SHIFT) && (bus.F_LEFT_NOT == ~bus.F_L_SHIFT) &&
             (bus.F_OLD_NOT == ~bus.F_NO_SHIFT) && (bus.F_RIGHT_NOT == ~bus.F_R_SHIFT) &&
             (bus.DOUT === bus.STG_IN) &&
             (bus.BUSY ? (c_act ^ f_act) : (!c_act && !f_act));
        check("invariants", {31'd0, ok}, 32'd1);
        if (!RST_N) begin
            run_cnt = 0;
        end else begin
            if (bus.BUSY === 1'b1) run_cnt++;
            if (bus.DONE === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("dout", bus.DOUT, exp_q.pop_front());
                    check("busy_cycles", 32'(run_cnt), 32'(exp_steps_q.pop_front()));
                end
                run_cnt = 0;
            end
        end
    end

    initial begin
        bus.START = 1'b0;
        bus.DIR   = 1'b0;
        bus.AMT   = '0;
        bus.DIN   = '0;
        repeat (3) @(negedge CLK);
        check_quiet_selects("reset");
        RST_N = 1'b1;
        @(negedge CLK);

        issue(1'b1, 5'd13, 32'h0000_0001);
        issue(1'b0, 5'd31, 32'h8000_0000);
        issue(1'b0, 5'd0,  32'hDEAD_BEEF);
        issue_after_done(1'b1, 5'd4, 32'h1234_5678);

        // Request during RUN must be dropped without disturbing the active shift.
        issue(1'b1, 5'd31, 32'h0000_0003);
        pulse_ignored();
        @(negedge CLK);
        pulse_ignored();
        issue_after_done(1'b0, 5'd7, 32'hF0F0_F0F0);

        // Reset in the second RUN cycle discards the shift and produces no DONE.
        issue(1'b1, 5'd20, 32'hA5A5_0001);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check_quiet_selects("mid_reset");
        void'(exp_q.pop_back());
        void'(exp_steps_q.pop_back());
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        check("post_reset_state", {30'd0, bus.state_dbg}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                issue_after_done(1'($urandom), 5'($urandom_range(0, 31)), $urandom);
            else
                issue(1'($urandom), 5'($urandom_range(0, 31)), $urandom);
        end
        issue(1'b1, 5'd31, 32'hFFFF_FFFF);
        issue(1'b0, 5'd3,  32'h0000_000F);

        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge CLK);
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Multi-cycle sequencer that performs a logical left or right shift of a 32-bit word by 0..31 positions. It reuses two external shift stages: a coarse stage that shifts by 4 and a fine stage that shifts by 1. It holds the working word in a register, drives the one-hot select lines and their complements to both stages, and writes back the output of the active stage each cycle. It sits between the ALU issue logic and the shifter datapath.

Parameters:
WIDTH, 32, datapath width; fixed by the shift stages.
AMT_W, 5, shift-amount width.
COARSE, 4, shift distance of the coarse stage.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
START  input  1  request pulse; accepted only when BUSY=0
DIR  input  1  1=left, 0=right; sampled with START
AMT  input  5  shift amount; sampled with START
DIN  input  32  operand; sampled with START
BUSY  output  1  high while shifting (RUN state)
DONE  output  1  one-cycle pulse, result valid
DOUT  output  32  working register; holds result until next accepted START
STG_IN  output  32  working register, fed to both stages
C_L_SHIFT, C_NO_SHIFT, C_R_SHIFT  output  1 each  coarse-stage one-hot select
C_LEFT_NOT, C_OLD_NOT, C_RIGHT_NOT  output  1 each  coarse-stage complements
F_L_SHIFT, F_NO_SHIFT, F_R_SHIFT  output  1 each  fine-stage one-hot select
F_LEFT_NOT, F_OLD_NOT, F_RIGHT_NOT  output  1 each  fine-stage complements
C_OUT  input  32  coarse-stage result
F_OUT  input  32  fine-stage result

Behaviour:
- States: IDLE, RUN, DONE. Registers: state, WREG[31:0], CNT[4:0], DIRR.
- Reset (async, RST_N=0): state=IDLE, WREG=0, CNT=0, DIRR=0. BUSY=0, DONE=0, DOUT=0. Both stages select NO_SHIFT=1, L/R=0, OLD_NOT=0, LEFT_NOT=RIGHT_NOT=1.
- Accept: at a rising edge with START=1 and state in {IDLE, DONE}: WREG<=DIN, CNT<=AMT, DIRR<=DIR. Next state is RUN if AMT!=0, else DONE.
- START while in RUN is ignored. No queuing, no error flag.
- RUN step, each edge:
  - If CNT>=4: coarse stage active; WREG<=C_OUT; CNT<=CNT-4.
  - Else: fine stage active; WREG<=F_OUT; CNT<=CNT-1.
  - Next state is DONE when the updated CNT==0.
- Step count = AMT/4 + AMT%4; no wrap or underflow of CNT.
- DONE state lasts exactly one cycle, then IDLE unless a START is accepted in that cycle.
- Latency: a START accepted at edge E0 gives DONE=1 during the cycle after edge E(steps). For AMT=0, DONE=1 in the cycle after E0.
- Select decode:
  - Combinational from registered state, CNT and DIRR only; no path from START, DIN, AMT or DIR.
  - In RUN, the active stage asserts L_SHIFT if DIRR=1, else R_SHIFT. The inactive stage, and both stages outside RUN, assert NO_SHIFT.
- Invariants, every cycle including reset:
  - Exactly one of L/NO/R is high per stage.
  - Each *_NOT equals the inverse of its partner (LEFT_NOT=~L_SHIFT, OLD_NOT=~NO_SHIFT, RIGHT_NOT=~R_SHIFT).
- Stages are logical: zero fill at both ends. The controller does not check the fill.
- BUSY = (state==RUN). DONE = (state==DONE). DOUT = STG_IN = WREG.
- Reset asserted mid-RUN: immediate return to reset values, no DONE pulse. The partial result is discarded.

Test Plan:
- DIN=0x0000_0001, DIR=1, AMT=13 -> coarse steps at E1..E3, fine step at E4. DONE=1 after E4, DOUT=0x0000_2000. BUSY high for exactly 4 cycles.
- DIN=0x8000_0000, DIR=0, AMT=31 -> 7 coarse steps then 3 fine steps. DONE after E10, DOUT=0x0000_0001.
- DIN=0xDEAD_BEEF, AMT=0 -> no RUN cycle, BUSY never high. DONE the cycle after E0, DOUT=0xDEAD_BEEF.
- START pulsed during RUN with DIN=0xFFFF_FFFF -> ignored; original result and step count unchanged. Back-to-back START in the DONE cycle is accepted.
- RST_N low at the 2nd RUN cycle of an AMT=20 left shift -> asynchronously DOUT=0, BUSY=0, both stages NO_SHIFT=1 and OLD_NOT=0. No DONE after release.
- Assertion over all runs: per-stage one-hot and complement invariants hold every cycle. The inactive stage is always NO_SHIFT.
